// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and the
// byte merge/extract helpers used for big-endian byte accesses.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F_RD,
    F_DONE,
    D_RD,
    D_DONE,
    D_WR,
    RMW_RD,
    RMW_WR
  } state_t;

  // Big-endian: byte address bit 0 = 0 selects the high byte of the word.
  function automatic logic [15:0] rmw_merge(input logic [15:0] old_word,
                                            input logic [7:0]  wbyte,
                                            input logic        lo);
    return lo ? {old_word[15:8], wbyte} : {wbyte, old_word[7:0]};
  endfunction

  function automatic logic [15:0] byte_extract(input logic [15:0] word,
                                               input logic        lo);
    return lo ? {8'h00, word[7:0]} : {8'h00, word[15:8]};
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single 16-bit word memory without byte
// enables; byte writes are done as read-modify-write.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [15:0]       f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_word,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [15:0]       d_wdata,
  output logic              d_ack,
  output logic [15:0]       d_rdata,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [15:0]       mem_data_o,
  input  logic [15:0]       mem_data_i,
  output logic              busy
);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       wdata_reg;
  logic              word_reg;

  // Requests are only looked at in IDLE; data port wins ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      word_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (d_req) begin
            addr_reg  <= d_addr;
            wdata_reg <= d_wdata;
            word_reg  <= d_word;
            if (!d_we)
              state_reg <= D_RD;
            else if (d_word)
              state_reg <= D_WR;
            else
              state_reg <= RMW_RD;
          end else if (f_req) begin
            addr_reg  <= f_addr;
            state_reg <= F_RD;
          end
        end
        F_RD:    state_reg <= F_DONE;
        D_RD:    state_reg <= D_DONE;
        RMW_RD:  state_reg <= RMW_WR;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs decode from the state register only, so an async reset clears
  // them in the same instant the state returns to IDLE.
  always_comb begin
    f_ack      = 1'b0;
    f_rdata    = '0;
    d_ack      = 1'b0;
    d_rdata    = '0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_data_o = '0;
    case (state_reg)
      F_RD, D_RD, RMW_RD: mem_re_o = 1'b1;
      F_DONE: begin
        f_ack   = 1'b1;
        f_rdata = mem_data_i;
      end
      D_DONE: begin
        d_ack   = 1'b1;
        d_rdata = word_reg ? mem_data_i : byte_extract(mem_data_i, addr_reg[0]);
      end
      D_WR: begin
        mem_we_o   = 1'b1;
        mem_data_o = wdata_reg;
        d_ack      = 1'b1;
      end
      RMW_WR: begin
        mem_we_o   = 1'b1;
        mem_data_o = rmw_merge(mem_data_i, wdata_reg[7:0], addr_reg[0]);
        d_ack      = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_addr_o = addr_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a word-addressed memory model that
// ignores address bit 0 and returns read data one cycle after mem_re_o.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic        d_word;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic [15:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        busy;

  logic        poke_en;
  logic [15:0] poke_addr;
  logic [15:0] poke_data;
  logic [15:0] mem [0:32767];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_ack      (f_ack),
    .f_rdata    (f_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_word     (d_word),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .mem_addr_o (mem_addr_o),
    .mem_re_o   (mem_re_o),
    .mem_we_o   (mem_we_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (poke_en)
      mem[poke_addr[15:1]] <= poke_data;
    else if (mem_we_o)
      mem[mem_addr_o[15:1]] <= mem_data_o;
    if (mem_re_o)
      mem_data_i <= mem[mem_addr_o[15:1]];
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("check %-14s observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    poke_en   = 1'b1;
    poke_addr = a;
    poke_data = v;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic data_req(input logic we, input logic word,
                          input logic [15:0] a, input logic [15:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_word  = word;
    d_addr  = a;
    d_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_word = 1'b0; d_addr = '0; d_wdata = '0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    mem_data_i = '0;

    // Reset state
    @(negedge clk);
    chkw("rst_ctrl", {11'd0, f_ack, d_ack, mem_re_o, mem_we_o, busy}, 16'h0000);
    chkw("rst_addr", mem_addr_o, 16'h0000);
    chkw("rst_data", mem_data_o | f_rdata | d_rdata, 16'h0000);
    rst_n = 1'b1;
    poke(16'h0100, 16'hBEEF);
    poke(16'h0200, 16'h5A5A);

    // Fetch: read strobe in cycle 1, ack with data in cycle 2
    f_req = 1'b1; f_addr = 16'h0100;
    @(negedge clk);
    chk ("f_rd_re", mem_re_o, 1'b1);
    chkw("f_rd_addr", mem_addr_o, 16'h0100);
    chk ("f_rd_ack", f_ack, 1'b0);
    @(negedge clk);
    chk ("f_done_ack", f_ack, 1'b1);
    chkw("f_done_data", f_rdata, 16'hBEEF);
    chk ("f_done_re", mem_re_o, 1'b0);
    f_req = 1'b0;
    @(negedge clk);
    chk ("f_idle_busy", busy, 1'b0);
    chk ("f_idle_ack", f_ack, 1'b0);

    // Simultaneous requests: data first, fetch after
    f_req = 1'b1; f_addr = 16'h0100;
    data_req(1'b0, 1'b1, 16'h0200, 16'h0000);
    @(negedge clk);
    chkw("pri_addr", mem_addr_o, 16'h0200);
    chk ("pri_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk ("pri_dack", d_ack, 1'b1);
    chk ("pri_fack", f_ack, 1'b0);
    chkw("pri_drdata", d_rdata, 16'h5A5A);
    d_req = 1'b0;
    @(negedge clk);
    chk ("pri_idle", busy, 1'b0);
    @(negedge clk);
    chkw("pri_f_addr", mem_addr_o, 16'h0100);
    chk ("pri_f_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk ("pri_f_ack", f_ack, 1'b1);
    chkw("pri_f_data", f_rdata, 16'hBEEF);
    f_req = 1'b0;
    @(negedge clk);

    // Byte write to odd address: RMW keeps high byte
    poke(16'h0300, 16'h1234);
    data_req(1'b1, 1'b0, 16'h0301, 16'h00AB);
    @(negedge clk);
    chk ("rmw1_re", mem_re_o, 1'b1);
    chk ("rmw1_we", mem_we_o, 1'b0);
    chk ("rmw1_ack", d_ack, 1'b0);
    @(negedge clk);
    chk ("rmw1_we2", mem_we_o, 1'b1);
    chk ("rmw1_re2", mem_re_o, 1'b0);
    chk ("rmw1_ack2", d_ack, 1'b1);
    chkw("rmw1_data", mem_data_o, 16'h12AB);
    chkw("rmw1_addr", mem_addr_o, 16'h0301);
    d_req = 1'b0;
    @(negedge clk);
    chkw("rmw1_mem", mem[16'h0300 >> 1], 16'h12AB);

    // Byte write to even address: RMW keeps low byte
    poke(16'h0300, 16'h1234);
    data_req(1'b1, 1'b0, 16'h0300, 16'h00AB);
    @(negedge clk);
    chk ("rmw0_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk ("rmw0_ack", d_ack, 1'b1);
    chkw("rmw0_data", mem_data_o, 16'hAB34);
    d_req = 1'b0;
    @(negedge clk);

    // Byte reads, big-endian
    poke(16'h0300, 16'h1234);
    data_req(1'b0, 1'b0, 16'h0301, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk ("brd1_ack", d_ack, 1'b1);
    chkw("brd1_data", d_rdata, 16'h0034);
    d_req = 1'b0;
    @(negedge clk);
    data_req(1'b0, 1'b0, 16'h0300, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    chk ("brd0_ack", d_ack, 1'b1);
    chkw("brd0_data", d_rdata, 16'h0012);
    d_req = 1'b0;
    @(negedge clk);

    // Word write: ack in cycle 1, address bit 0 passed through
    data_req(1'b1, 1'b1, 16'h0401, 16'hCAFE);
    @(negedge clk);
    chk ("ww_we", mem_we_o, 1'b1);
    chk ("ww_re", mem_re_o, 1'b0);
    chk ("ww_ack", d_ack, 1'b1);
    chkw("ww_addr", mem_addr_o, 16'h0401);
    chkw("ww_data", mem_data_o, 16'hCAFE);
    // Request held past ack is served again as a word read
    d_we = 1'b0;
    @(negedge clk);
    chk ("hold_idle", busy, 1'b0);
    chk ("hold_noack", d_ack, 1'b0);
    @(negedge clk);
    chk ("hold_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk ("hold_ack", d_ack, 1'b1);
    chkw("hold_data", d_rdata, 16'hCAFE);
    d_req = 1'b0;
    @(negedge clk);

    // Reset in the middle of an RMW
    data_req(1'b1, 1'b0, 16'h0301, 16'h00FF);
    @(negedge clk);
    chk ("ar_rmw_re", mem_re_o, 1'b1);
    rst_n = 1'b0;
    d_req = 1'b0;
    #1;
    chkw("ar_ctrl", {11'd0, f_ack, d_ack, mem_re_o, mem_we_o, busy}, 16'h0000);
    chkw("ar_addr", mem_addr_o, 16'h0000);
    chkw("ar_data", mem_data_o | f_rdata | d_rdata, 16'h0000);
    @(negedge clk);
    chk ("ar_noack", d_ack, 1'b0);
    chk ("ar_nowe", mem_we_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk ("ar_idle", busy, 1'b0);
    chk ("ar_noack2", d_ack, 1'b0);
    chkw("ar_mem", mem[16'h0300 >> 1], 16'h1234);
    data_req(1'b0, 1'b1, 16'h0300, 16'h0000);
    @(negedge clk);
    chk ("ar_post_re", mem_re_o, 1'b1);
    @(negedge clk);
    chk ("ar_post_ack", d_ack, 1'b1);
    chkw("ar_post_data", d_rdata, 16'h1234);
    d_req = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
